// File: rtl/result_drain.sv
// Drains a systolic-array result matrix as a row-major ready/valid element stream.
// Define RESULT_DRAIN_SAT_EN to clamp elements to OUT_WIDTH instead of truncating them.
module result_drain #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned SIZE      = 10,
    parameter int unsigned LATENCY   = 2 * SIZE + 2,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                                                     clk,
    input  logic                                                     reset_n,
    input  logic                                                     start,
    input  logic                                                     flush,
    input  logic signed [SIZE*SIZE*(WIDTH*2+$clog2(SIZE)+1)-1:0]     result_matrix,
    output logic                                                     out_valid,
    input  logic                                                     out_ready,
    output logic signed [OUT_WIDTH-1:0]                              out_data,
    output logic [$clog2(SIZE)-1:0]                                  out_row,
    output logic [$clog2(SIZE)-1:0]                                  out_col,
    output logic                                                     out_last,
    output logic                                                     busy,
    output logic                                                     done,
    output logic                                                     sat_flag
);

    localparam int unsigned RW  = WIDTH * 2 + $clog2(SIZE) + 1;
    localparam int unsigned NE  = SIZE * SIZE;
    localparam int unsigned IXW = $clog2(SIZE);
    localparam int unsigned EW  = $clog2(NE);
    localparam int unsigned CW  = $clog2(LATENCY + 1);
    localparam int unsigned MW  = (OUT_WIDTH > RW) ? OUT_WIDTH : RW;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        CAPTURE,
        DRAIN,
        DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          buf_q [NE];
    logic [RW-1:0]          buf_d [NE];
    logic                   valid_q, valid_d;
    logic [OUT_WIDTH-1:0]   data_q, data_d;
    logic [IXW-1:0]         row_q, row_d;
    logic [IXW-1:0]         col_q, col_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sat_q, sat_d;
    logic                   elem_sat_q, elem_sat_d;

    logic [IXW-1:0]         row_n, col_n;
    logic [EW-1:0]          eidx;
    logic [OUT_WIDTH:0]     conv;
    logic                   drain_n;

    // Returns {clamped, value}: value is the element narrowed/widened to OUT_WIDTH.
    function automatic logic [OUT_WIDTH:0] convert(input logic [RW-1:0] e);
        logic signed [MW-1:0] ex;
        logic [OUT_WIDTH-1:0] d;
        logic                 s;
        ex = MW'($signed(e));
        d  = ex[OUT_WIDTH-1:0];
        s  = 1'b0;
`ifdef RESULT_DRAIN_SAT_EN
        if (!((ex[MW-1:OUT_WIDTH-1] == '0) || (ex[MW-1:OUT_WIDTH-1] == '1))) begin
            s = 1'b1;
            d = ex[MW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
`endif
        return {s, d};
    endfunction

    // Next-state, index and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        sat_d   = sat_q;
        row_n   = row_q;
        col_n   = col_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                    sat_d   = 1'b0;
                end
            end
            WAIT: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            CAPTURE: begin
                for (int i = 0; i < NE; i++) buf_d[i] = result_matrix[i*RW +: RW];
                row_n   = '0;
                col_n   = '0;
                state_d = DRAIN;
            end
            DRAIN: begin
                if (valid_q && out_ready) begin
                    if (elem_sat_q) sat_d = 1'b1;
                    if (last_q) begin
                        state_d = DONE;
                    end else if (col_q == IXW'(SIZE - 1)) begin
                        col_n = '0;
                        row_n = row_q + IXW'(1);
                    end else begin
                        col_n = col_q + IXW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort wins over everything, including a start seen in IDLE.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
            sat_d   = sat_q;
        end

        drain_n    = (state_d == DRAIN);
        eidx       = EW'(row_n) * EW'(SIZE) + EW'(col_n);
        conv       = convert(buf_d[eidx]);

        valid_d    = drain_n;
        data_d     = drain_n ? conv[OUT_WIDTH-1:0] : '0;
        elem_sat_d = drain_n & conv[OUT_WIDTH];
        row_d      = drain_n ? row_n : '0;
        col_d      = drain_n ? col_n : '0;
        last_d     = drain_n && (row_n == IXW'(SIZE - 1)) && (col_n == IXW'(SIZE - 1));
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            elem_sat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            row_q      <= row_d;
            col_q      <= col_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sat_q      <= sat_d;
            elem_sat_q <= elem_sat_d;
        end
    end

    // Snapshot storage needs no reset: it is only read after a CAPTURE.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_row   = row_q;
    assign out_col   = col_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    // Without saturation elem_sat never sets, so this is constant zero.
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain (SIZE=2, OUT_WIDTH=8) against a frame-level reference model.
module tb_result_drain;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned SIZE      = 2;
    localparam int unsigned LATENCY   = 6;
    localparam int unsigned OUT_WIDTH = 8;
    localparam int unsigned RW        = WIDTH * 2 + $clog2(SIZE) + 1;
    localparam int unsigned NE        = SIZE * SIZE;
    localparam longint      OMAX      = (longint'(1) << (OUT_WIDTH - 1)) - 1;
    localparam longint      OMIN      = -OMAX - 1;

    logic                          clk = 1'b0;
    logic                          reset_n = 1'b0;
    logic                          start = 1'b0;
    logic                          flush = 1'b0;
    logic                          out_ready = 1'b0;
    logic signed [NE*RW-1:0]       result_matrix = '0;
    logic                          out_valid;
    logic signed [OUT_WIDTH-1:0]   out_data;
    logic [$clog2(SIZE)-1:0]       out_row;
    logic [$clog2(SIZE)-1:0]       out_col;
    logic                          out_last;
    logic                          busy;
    logic                          done;
    logic                          sat_flag;

    result_drain #(
        .WIDTH    (WIDTH),
        .SIZE     (SIZE),
        .LATENCY  (LATENCY),
        .OUT_WIDTH(OUT_WIDTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .flush        (flush),
        .result_matrix(result_matrix),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    int     n_assert = 0;
    int     n_fail   = 0;
    longint mat [NE];
    int     ready_mode;
    bit     extra_start;
    int     flush_after;
    int     reset_after;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint exp_data(input longint e);
`ifdef RESULT_DRAIN_SAT_EN
        if (e > OMAX) return OMAX;
        if (e < OMIN) return OMIN;
        return e;
`else
        longint t;
        t = e & ((longint'(1) << OUT_WIDTH) - 1);
        if (t > OMAX) t = t - (longint'(1) << OUT_WIDTH);
        return t;
`endif
    endfunction

    function automatic bit exp_clamp(input longint e);
`ifdef RESULT_DRAIN_SAT_EN
        return (e > OMAX) || (e < OMIN);
`else
        return (e != e + 1) && 1'b0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_done"},  done,      0);
        chk({tag, "_busy"},  busy,      0);
        chk({tag, "_last"},  out_last,  0);
        chk({tag, "_data"},  out_data,  0);
    endtask

    // Runs one frame from start, checking every cycle against the model.
    task automatic run_frame(input string tag);
        int first_c, done_c, done_cnt, n;
        bit sat_exp, rdy, aborted, pend_flush, pend_reset;
        for (int i = 0; i < NE; i++) result_matrix[i*RW +: RW] = RW'(mat[i]);
        first_c = -1; done_c = -1; done_cnt = 0; n = 0;
        sat_exp = 1'b0; aborted = 1'b0; pend_flush = 1'b0; pend_reset = 1'b0;
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            chk({tag, "_sat_flag"}, sat_flag, sat_exp);
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_out_valid"}, out_valid, (c >= int'(LATENCY) + 1) && (n < int'(NE)));
            if (done) begin
                done_cnt++;
                done_c = c;
                chk({tag, "_done_count_elems"}, n, NE);
            end
            if (out_valid) begin
                if (first_c < 0) first_c = c;
                if (n < int'(NE)) begin
                    chk({tag, "_data"}, out_data, exp_data(mat[n]));
                    chk({tag, "_row"},  out_row,  n / int'(SIZE));
                    chk({tag, "_col"},  out_col,  n % int'(SIZE));
                    chk({tag, "_last"}, out_last, n == int'(NE) - 1);
                end else begin
                    chk({tag, "_extra_element"}, n, NE - 1);
                end
            end
            if (pend_flush) begin
                flush = 1'b1;
                out_ready = 1'b0;
                step();
                flush = 1'b0;
                chk({tag, "_flush_valid"}, out_valid, 0);
                chk({tag, "_flush_busy"},  busy, 0);
                for (int k = 0; k < 4; k++) begin
                    chk({tag, "_flush_no_done"}, done, 0);
                    step();
                end
                aborted = 1'b1;
                break;
            end
            if (pend_reset) begin
                reset_n = 1'b0;
                out_ready = 1'b0;
                step();
                check_idle({tag, "_rst"});
                chk({tag, "_rst_row"}, out_row, 0);
                chk({tag, "_rst_col"}, out_col, 0);
                chk({tag, "_rst_sat"}, sat_flag, 0);
                reset_n = 1'b1;
                step();
                check_idle({tag, "_postrst"});
                aborted = 1'b1;
                break;
            end
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (c % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            start = extra_start && (c == 2 || (first_c >= 0 && c == first_c + 1) || done);
            if (out_valid && rdy && n < int'(NE)) begin
                if (exp_clamp(mat[n])) sat_exp = 1'b1;
                n++;
                if (n == flush_after) pend_flush = 1'b1;
                if (n == reset_after) pend_reset = 1'b1;
            end
            if (done) break;
            step();
        end
        out_ready = 1'b0;
        if (!aborted) begin
            step();
            start = 1'b0;
            chk({tag, "_elements"}, n, NE);
            chk({tag, "_done_pulses"}, done_cnt, 1);
            if (ready_mode == 0) begin
                chk({tag, "_first_valid_cycle"}, first_c, LATENCY + 1);
                chk({tag, "_done_cycle"}, done_c, LATENCY + 1 + NE);
            end
            for (int k = 0; k < 3; k++) begin
                chk({tag, "_post_busy"},  busy, 0);
                chk({tag, "_post_done"},  done, 0);
                chk({tag, "_post_valid"}, out_valid, 0);
                step();
            end
        end
        start = 1'b0;
    endtask

    initial begin
        longint bnd [4];
        bnd = '{OMAX, OMAX + 1, OMIN, OMIN - 1};
        flush_after = -1; reset_after = -1; ready_mode = 0; extra_start = 1'b0;

        reset_n = 1'b0;
        step();
        step();
        check_idle("reset");
        chk("reset_sat", sat_flag, 0);
        chk("reset_row", out_row, 0);
        chk("reset_col", out_col, 0);
        reset_n = 1'b1;
        step();

        mat = '{1, 2, 3, 4};
        run_frame("basic");

        ready_mode = 1;
        run_frame("stall");

        ready_mode = 0; extra_start = 1'b1;
        run_frame("extra_start");
        extra_start = 1'b0;

        flush_after = 2;
        run_frame("flush_drain");
        flush_after = -1;

        start = 1'b1; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_wait_busy", busy, 0);
        step();
        chk("flush_wait_idle", busy, 0);

        mat = '{300, -300, 5, -1};
        run_frame("sat");

        mat = '{1, 2, 3, 4};
        reset_after = 1;
        run_frame("reset_mid");
        reset_after = -1;
        run_frame("after_reset");

        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < int'(NE); i++) begin
                case ($urandom_range(0, 3))
                    0:       mat[i] = longint'($urandom_range(0, 255)) - 128;
                    1:       mat[i] = longint'($urandom_range(0, 4000)) - 2000;
                    2:       mat[i] = bnd[$urandom_range(0, 3)];
                    default: mat[i] = longint'($urandom) - 64'sd2147483648;
                endcase
            end
            ready_mode = (f % 2 == 0) ? 2 : 0;
            run_frame("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
